// File: rtl/ifmap_read_addr_gen.sv
// Read-address generator for the ifmap BRAM of one convolution tile, driven by the microsequencer read strobe.
// Optional sticky overrun detection when IFMAP_ADDR_OVERRUN_EN is defined.
module ifmap_read_addr_gen #(
    parameter int unsigned DIMENSION = 16,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [9:0]        tile_offset,
    input  logic [9:0]        temporal_length,
    input  logic [4:0]        kernel_size,
    input  logic [1:0]        stride,
    input  logic [2:0]        padding,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              rd_valid,
    output logic              ifmap_counter_done,
    output logic              ifmap_flag_1per16,
    output logic [9:0]        words_total,
    output logic              busy
`ifdef IFMAP_ADDR_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int unsigned CW = 10;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [CW-1:0] count, count_inc;
    logic [CW-1:0] off_r, len_r;
    logic [4:0]    k_r;
    logic [1:0]    stride_r;
    logic [2:0]    pad_r;
    logic [CW-1:0] stride_val, n_in, need, avail, words;
    logic          accept, last;

    // Tile word count from the latched configuration, all in 10-bit arithmetic
    always_comb begin
        stride_val = (stride_r < 2'd2) ? CW'(1) : CW'(stride_r);
        n_in       = CW'(CW'(DIMENSION - 1) * stride_val) + CW'(k_r);
        need       = (n_in > CW'(pad_r)) ? n_in - CW'(pad_r) : CW'(0);
        avail      = (len_r > off_r) ? len_r - off_r : CW'(0);
        words      = (need < avail) ? need : avail;
    end

    assign count_inc = count + CW'(1);
    assign accept    = en && !start && (state == RUN) && (count < words_total);
    assign last      = accept && (count_inc == words_total);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = LOAD;
            LOAD: begin
                if (start)              state_nx = LOAD;
                else if (words == '0)   state_nx = DONE;
                else                    state_nx = RUN;
            end
            RUN: begin
                if (start)     state_nx = LOAD;
                else if (last) state_nx = DONE;
            end
            DONE: if (start) state_nx = LOAD;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: config latch, read counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count              <= '0;
            off_r              <= '0;
            len_r              <= '0;
            k_r                <= '0;
            stride_r           <= '0;
            pad_r              <= '0;
            bram_addr          <= '0;
            rd_valid           <= 1'b0;
            ifmap_counter_done <= 1'b0;
            ifmap_flag_1per16  <= 1'b0;
            words_total        <= '0;
            busy               <= 1'b0;
`ifdef IFMAP_ADDR_OVERRUN_EN
            overrun            <= 1'b0;
`endif
        end else begin
            rd_valid          <= accept;
            ifmap_flag_1per16 <= accept && (count_inc[3:0] == 4'd0);
            busy              <= (state_nx == LOAD) || (state_nx == RUN);
            if (start) begin
                off_r              <= tile_offset;
                len_r              <= temporal_length;
                k_r                <= kernel_size;
                stride_r           <= stride;
                pad_r              <= padding;
                count              <= '0;
                bram_addr          <= base_addr + ADDR_W'(tile_offset);
                ifmap_counter_done <= 1'b0;
`ifdef IFMAP_ADDR_OVERRUN_EN
                overrun            <= 1'b0;
`endif
            end else begin
                if (state == LOAD) begin
                    words_total <= words;
                    if (words == '0) ifmap_counter_done <= 1'b1;
                end
                if (accept) begin
                    count     <= count_inc;
                    bram_addr <= bram_addr + ADDR_W'(1);
                    if (last) ifmap_counter_done <= 1'b1;
                end
`ifdef IFMAP_ADDR_OVERRUN_EN
                if (en && (state == DONE)) overrun <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ifmap_read_addr_gen.sv
// Directed self-checking bench for ifmap_read_addr_gen; overrun checks only when IFMAP_ADDR_OVERRUN_EN is defined.
module tb_ifmap_read_addr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, en;
    logic [9:0] base_addr, tile_offset, temporal_length;
    logic [4:0] kernel_size;
    logic [1:0] stride;
    logic [2:0] padding;
    logic [9:0] bram_addr;
    logic       rd_valid, ifmap_counter_done, ifmap_flag_1per16, busy;
    logic [9:0] words_total;
`ifdef IFMAP_ADDR_OVERRUN_EN
    logic       overrun;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ifmap_read_addr_gen dut (
        .clk(clk), .rst(rst), .start(start), .en(en),
        .base_addr(base_addr), .tile_offset(tile_offset),
        .temporal_length(temporal_length), .kernel_size(kernel_size),
        .stride(stride), .padding(padding),
        .bram_addr(bram_addr), .rd_valid(rd_valid),
        .ifmap_counter_done(ifmap_counter_done),
        .ifmap_flag_1per16(ifmap_flag_1per16),
        .words_total(words_total), .busy(busy)
`ifdef IFMAP_ADDR_OVERRUN_EN
        , .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start with a configuration; returns after LOAD has resolved
    task automatic do_start(input logic [9:0] b, input logic [9:0] off, input logic [9:0] len,
                            input logic [4:0] k, input logic [1:0] s, input logic [2:0] p);
        @(negedge clk);
        start = 1'b1; en = 1'b0;
        base_addr = b; tile_offset = off; temporal_length = len;
        kernel_size = k; stride = s; padding = p;
        @(negedge clk);
        start = 1'b0;
        check("load_busy", int'(busy), 1);
        check("load_done_clr", int'(ifmap_counter_done), 0);
        @(negedge clk);
    endtask

    // Drive en (held or toggled) and observe reads until done, an abort point, or timeout
    task automatic run_tile(input int toggle, input int abort_at, input logic [9:0] exp_base,
                            output int reads, output int flags, output int en_cnt,
                            output int addr_err, output int done_with_last, output int timed_out);
        logic [9:0] prev_addr;
        logic [9:0] exp_addr;
        reads = 0; flags = 0; en_cnt = 0; addr_err = 0; done_with_last = 0; timed_out = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            prev_addr = bram_addr;
            en = (toggle != 0) ? ((cyc % 2) == 0) : 1'b1;
            if (en) en_cnt++;
            @(negedge clk);
            if (rd_valid) begin
                exp_addr = exp_base + 10'(reads);
                if (prev_addr != exp_addr) addr_err++;
                reads++;
            end
            if (ifmap_flag_1per16) flags++;
            if (ifmap_counter_done) begin
                done_with_last = int'(rd_valid);
                timed_out = 0;
                break;
            end
            if (abort_at > 0 && reads == abort_at) begin
                timed_out = 0;
                break;
            end
        end
        en = 1'b0;
    endtask

    int rd, fl, ec, ae, dl, to;

    initial begin
        rst = 1'b0; start = 1'b0; en = 1'b0;
        base_addr = '0; tile_offset = '0; temporal_length = '0;
        kernel_size = '0; stride = '0; padding = '0;
        #12;
        check("rst_addr", int'(bram_addr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(ifmap_counter_done), 0);
        check("rst_words", int'(words_total), 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: stride 1, k 3, pad 1 -> 17 words from 0x040
        do_start(10'h040, 10'd0, 10'd100, 5'd3, 2'd1, 3'd1);
        check("t1_words", int'(words_total), 17);
        run_tile(0, 0, 10'h040, rd, fl, ec, ae, dl, to);
        check("t1_timeout", to, 0);
        check("t1_reads", rd, 17);
        check("t1_addr_err", ae, 0);
        check("t1_flags", fl, 1);
        check("t1_done_after_last", dl, 1);
        check("t1_en_cnt", ec, 17);
        check("t1_last_addr", int'(bram_addr), 10'h051);
        @(negedge clk);
        check("t1_done_hold", int'(ifmap_counter_done), 1);
        check("t1_busy_low", int'(busy), 0);

        // 2: stride 2, k 5, pad 2, avail-limited -> 20 words from base+20
        do_start(10'h100, 10'd20, 10'd40, 5'd5, 2'd2, 3'd2);
        check("t2_words", int'(words_total), 20);
        run_tile(0, 0, 10'h114, rd, fl, ec, ae, dl, to);
        check("t2_timeout", to, 0);
        check("t2_reads", rd, 20);
        check("t2_addr_err", ae, 0);
        check("t2_flags", fl, 1);
        check("t2_done_after_last", dl, 1);

        // 3: offset == temporal_length -> zero words, straight to DONE
        do_start(10'h000, 10'd50, 10'd50, 5'd3, 2'd1, 3'd0);
        check("t3_words", int'(words_total), 0);
        check("t3_done", int'(ifmap_counter_done), 1);
        check("t3_busy", int'(busy), 0);
        check("t3_no_valid", int'(rd_valid), 0);

        // 4: en toggling, k 3, pad 0 -> 18 words
        do_start(10'h020, 10'd0, 10'd100, 5'd3, 2'd0, 3'd0);
        check("t4_words", int'(words_total), 18);
        run_tile(1, 0, 10'h020, rd, fl, ec, ae, dl, to);
        check("t4_timeout", to, 0);
        check("t4_reads", rd, 18);
        check("t4_en_cnt", ec, 18);
        check("t4_addr_err", ae, 0);
        check("t4_flags", fl, 1);

        // 5: restart at count 7 with en high, then async reset mid-tile
        do_start(10'h080, 10'd0, 10'd100, 5'd3, 2'd1, 3'd0);
        run_tile(0, 7, 10'h080, rd, fl, ec, ae, dl, to);
        check("t5_timeout", to, 0);
        check("t5_addr_at7", int'(bram_addr), 10'h087);
        start = 1'b1; en = 1'b1;
        @(negedge clk);
        start = 1'b0; en = 1'b0;
        check("t5_abort_valid", int'(rd_valid), 0);
        check("t5_abort_busy", int'(busy), 1);
        check("t5_abort_addr", int'(bram_addr), 10'h080);
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_run_addr", int'(bram_addr), 10'h083);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_addr", int'(bram_addr), 0);
        check("t5_rst_valid", int'(rd_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_words", int'(words_total), 0);
        check("t5_rst_done", int'(ifmap_counter_done), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

`ifdef IFMAP_ADDR_OVERRUN_EN
        // 6: address wrap and overrun
        do_start(10'h3FE, 10'd0, 10'd100, 5'd3, 2'd1, 3'd1);
        run_tile(0, 0, 10'h3FE, rd, fl, ec, ae, dl, to);
        check("t6_timeout", to, 0);
        check("t6_reads", rd, 17);
        check("t6_addr_err", ae, 0);
        check("t6_last_addr", int'(bram_addr), 10'h00F);
        check("t6_no_overrun", int'(overrun), 0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("t6_overrun", int'(overrun), 1);
        do_start(10'h000, 10'd0, 10'd100, 5'd3, 2'd1, 3'd1);
        check("t6_overrun_clr", int'(overrun), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
